// File: rtl/gpr_pkg.sv
// Shared sizing and types for the general-register write bank.
package gpr_pkg;

  localparam int unsigned DATA_W   = 32;
  localparam int unsigned ADDR_W   = 5;
  localparam int unsigned NUM_REGS = 1 << ADDR_W;

  localparam logic [ADDR_W-1:0] ZERO_REG = 5'd0;

  typedef logic [DATA_W-1:0] gpr_t;
  typedef logic [ADDR_W-1:0] gpr_addr_t;

endpackage

// File: rtl/gpr_write_decoder.sv
// One-hot register-select decoder with enable; GR0 is never selected.
module gpr_write_decoder
  import gpr_pkg::*;
#(
  parameter int unsigned ADDR_W   = gpr_pkg::ADDR_W,
  parameter int unsigned NUM_REGS = 2 ** ADDR_W
) (
  input  logic                i_en,
  input  logic [ADDR_W-1:0]   i_addr,
  output logic [NUM_REGS-1:0] o_onehot
);

  always_comb begin
    o_onehot = '0;
    if (i_en) o_onehot[i_addr] = 1'b1;
    o_onehot[ZERO_REG] = 1'b0;
  end

endmodule

// File: rtl/gpr_write_bank.sv
// GPR storage, write decode and busy scoreboard driving the read-mux bus.
// Optional same-cycle write bypass onto the outputs: GPR_WRITE_BYPASS_EN.
module gpr_write_bank
  import gpr_pkg::*;
#(
  parameter int unsigned       DATA_W    = gpr_pkg::DATA_W,
  parameter int unsigned       ADDR_W    = gpr_pkg::ADDR_W,
  parameter int unsigned       NUM_REGS  = 2 ** ADDR_W,
  parameter logic [DATA_W-1:0] RESET_VAL = '0
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         wr_en,
  input  logic [ADDR_W-1:0]            wr_addr,
  input  logic [DATA_W-1:0]            wr_data,
  input  logic                         iss_en,
  input  logic [ADDR_W-1:0]            iss_addr,
  output logic [NUM_REGS*DATA_W-1:0]   regs_flat,
  output logic [NUM_REGS-1:0]          busy,
  output logic                         wr_collide
);

  logic [NUM_REGS-1:0] w_wr_hot;
  logic [NUM_REGS-1:0] w_iss_hot;
  logic [DATA_W-1:0]   r_regs [NUM_REGS];
  logic [NUM_REGS-1:0] r_busy;
  logic                r_wr_collide;

  gpr_write_decoder #(
    .ADDR_W  (ADDR_W),
    .NUM_REGS(NUM_REGS)
  ) u_wr_dec (
    .i_en    (wr_en),
    .i_addr  (wr_addr),
    .o_onehot(w_wr_hot)
  );

  gpr_write_decoder #(
    .ADDR_W  (ADDR_W),
    .NUM_REGS(NUM_REGS)
  ) u_iss_dec (
    .i_en    (iss_en),
    .i_addr  (iss_addr),
    .o_onehot(w_iss_hot)
  );

  // Entry 0 and busy bit 0 are only ever cleared, so they stay constant zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned n = 0; n < NUM_REGS; n++) begin
        r_regs[n] <= (n == 0) ? '0 : RESET_VAL;
      end
      r_busy       <= '0;
      r_wr_collide <= 1'b0;
    end else begin
      for (int unsigned n = 1; n < NUM_REGS; n++) begin
        if (w_wr_hot[n]) r_regs[n] <= wr_data;
        if (w_iss_hot[n])     r_busy[n] <= 1'b1;
        else if (w_wr_hot[n]) r_busy[n] <= 1'b0;
      end
      r_wr_collide <= |(w_wr_hot & ~r_busy);
    end
  end

  always_comb begin
    regs_flat = '0;
    busy      = r_busy;
    for (int unsigned n = 0; n < NUM_REGS; n++) begin
      regs_flat[n*DATA_W +: DATA_W] = r_regs[n];
`ifdef GPR_WRITE_BYPASS_EN
      if (w_wr_hot[n]) begin
        regs_flat[n*DATA_W +: DATA_W] = wr_data;
        busy[n]                       = w_iss_hot[n];
      end
`endif
    end
  end

  assign wr_collide = r_wr_collide;

endmodule

// File: tb/tb_gpr_write_bank.sv
// Randomised bench for gpr_write_bank against an array-based register-file model.
module tb_gpr_write_bank;

  logic          clk;
  logic          rst;
  logic          wr_en;
  logic [4:0]    wr_addr;
  logic [31:0]   wr_data;
  logic          iss_en;
  logic [4:0]    iss_addr;
  logic [1023:0] regs_flat;
  logic [31:0]   busy;
  logic          wr_collide;

  int checks   = 0;
  int failures = 0;

`ifdef GPR_WRITE_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  gpr_write_bank dut (
    .clk       (clk),
    .rst       (rst),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .iss_en    (iss_en),
    .iss_addr  (iss_addr),
    .regs_flat (regs_flat),
    .busy      (busy),
    .wr_collide(wr_collide)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference model: plain arrays of register contents and outstanding producers.
  logic [31:0] m_regs [32];
  bit          m_busy [32];
  bit          m_col;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int n = 0; n < 32; n++) begin
        m_regs[n] <= 32'h0;
        m_busy[n] <= 1'b0;
      end
      m_col <= 1'b0;
    end else begin
      m_col <= wr_en && (wr_addr != 0) && !m_busy[wr_addr];
      if (wr_en && wr_addr != 0) begin
        m_regs[wr_addr] <= wr_data;
        m_busy[wr_addr] <= 1'b0;
      end
      if (iss_en && iss_addr != 0) m_busy[iss_addr] <= 1'b1;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] gr(input int n);
    return regs_flat[n*32 +: 32];
  endfunction

  bit cmp_on = 1'b0;

  always @(negedge clk) begin
    if (cmp_on) begin
      logic [31:0] ev;
      bit          eb;
      for (int n = 0; n < 32; n++) begin
        bool_wr: begin
          bit hit;
          hit = BYPASS && wr_en && (wr_addr == n) && (n != 0);
          ev  = hit ? wr_data : m_regs[n];
          eb  = hit ? (iss_en && iss_addr == n) : m_busy[n];
        end
        chk($sformatf("model_GR%0d", n), gr(n), ev);
        chk($sformatf("model_busy%0d", n), {31'h0, busy[n]}, {31'h0, eb});
      end
      chk("model_collide", {31'h0, wr_collide}, {31'h0, m_col});
    end
  end

  task automatic step(input logic we, input logic [4:0] wa, input logic [31:0] wd,
                      input logic ie, input logic [4:0] ia);
    @(posedge clk);
    #1;
    wr_en = we; wr_addr = wa; wr_data = wd;
    iss_en = ie; iss_addr = ia;
  endtask

  task automatic idle();
    step(1'b0, 5'd0, 32'h0, 1'b0, 5'd0);
  endtask

  initial begin
    rst = 1'b1;
    wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    iss_en = 1'b0; iss_addr = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_GR1", gr(1), 32'h0);
    chk("reset_GR31", gr(31), 32'h0);
    chk("reset_busy", busy, 32'h0);
    chk("reset_collide", {31'h0, wr_collide}, 32'h0);
    rst = 1'b0;
    cmp_on = 1'b1;

    // Write GR5; every other register stays at reset value.
    step(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0);
    idle();
    chk("wr5_GR5", gr(5), 32'hDEADBEEF);
    chk("wr5_GR4", gr(4), 32'h0);
    chk("wr5_GR6", gr(6), 32'h0);

    // Write to GR0 is ignored.
    step(1'b1, 5'd0, 32'hFFFFFFFF, 1'b1, 5'd0);
    idle();
    chk("wr0_GR0", gr(0), 32'h0);
    chk("wr0_busy0", {31'h0, busy[0]}, 32'h0);
    chk("wr0_collide", {31'h0, wr_collide}, 32'h0);

    // Issue then simultaneous issue+writeback on GR7.
    step(1'b0, 5'd0, 32'h0, 1'b1, 5'd7);
    idle();
    chk("iss7_busy7", {31'h0, busy[7]}, 32'h1);
    step(1'b1, 5'd7, 32'h0000A5A5, 1'b1, 5'd7);
    idle();
    chk("isswr7_busy7", {31'h0, busy[7]}, 32'h1);
    chk("isswr7_GR7", gr(7), 32'h0000A5A5);
    chk("isswr7_collide", {31'h0, wr_collide}, 32'h0);

    // Unmatched writeback to GR9 flags collide for one cycle only.
    step(1'b1, 5'd9, 32'h99990009, 1'b0, 5'd0);
    idle();
    chk("wr9_GR9", gr(9), 32'h99990009);
    chk("wr9_collide", {31'h0, wr_collide}, 32'h1);
    idle();
    chk("wr9_collide_drop", {31'h0, wr_collide}, 32'h0);

    // Same-cycle read of GR31 during its writeback.
    step(1'b1, 5'd31, 32'h00001234, 1'b0, 5'd0);
    #1;
    chk("wr31_same_cycle", gr(31), BYPASS ? 32'h00001234 : 32'h0);
    idle();
    chk("wr31_next_cycle", gr(31), 32'h00001234);

    // Randomised traffic, with an asynchronous reset dropped in partway.
    for (int i = 0; i < 600; i++) begin
      logic [4:0] wa, ia;
      wa = ($urandom_range(3) == 0) ? 5'($urandom_range(31)) : 5'($urandom_range(7));
      ia = ($urandom_range(3) == 0) ? 5'($urandom_range(31)) : 5'($urandom_range(7));
      step(1'($urandom_range(1)), wa, $urandom, 1'($urandom_range(1)), ia);
      if (i == 300) begin
        #2;
        rst = 1'b1;
        #1;
        chk("midrst_regs_lo", regs_flat[31:0] | gr(1) | gr(5) | gr(7) | gr(9), 32'h0);
        chk("midrst_GR31", gr(31), 32'h0);
        chk("midrst_busy", busy, 32'h0);
        chk("midrst_collide", {31'h0, wr_collide}, 32'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;
      end
    end
    idle();
    idle();
    cmp_on = 1'b0;
    @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1);
  end

endmodule
